// File: rtl/spkr_drv_mc.sv
// Purpose: multi-channel PCM frame buffer feeding one first-order PDM modulator per channel.
// Latency: a popped frame changes PDM density 2 clk after the smpl_tick that pops it.
// Backpressure: rdy = !full; a vld presented while full is ignored and that frame is dropped.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   vld / rdy   frame handshake from the EQ engine; chnnl_in carries NCH signed W-bit samples,
//               channel k at [k*W +: W]
//   smpl_tick   one-cycle sample-rate strobe; pops one frame when the FIFO is not empty
//   mute        level input forcing silence (hard midscale, or a gain ramp with soft mute)
//   PDM/PDM_n   per-channel PDM bitstream and its complement, both straight from flops
//   underrun    sticky flag: a tick found the FIFO empty; clr_err clears it and wins over a set
//   fifo_cnt    frames currently buffered, 0..DEPTH
//
// Build option: define SPKR_SOFT_MUTE_EN to replace the hard mute with a per-channel
// 32-step attenuation ramp advanced by smpl_tick.

module spkr_drv_mc #(
    parameter int NCH   = 2,
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vld,
    output logic                   rdy,
    input  logic [NCH*W-1:0]       chnnl_in,
    input  logic                   smpl_tick,
    input  logic                   mute,
    output logic [NCH-1:0]         PDM,
    output logic [NCH-1:0]         PDM_n,
    output logic                   underrun,
    input  logic                   clr_err,
    output logic [$clog2(DEPTH):0] fifo_cnt
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            CW       = AW + 1;
    localparam logic [W-1:0]  MID      = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // Frame FIFO. DEPTH is a power of two, so the pointers wrap naturally;
    // the separate count distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [NCH*W-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             fifo_empty;
    logic             push_vld;
    logic             pop_vld;
    logic [NCH*W-1:0] rd_dat;

    assign rdy        = (cnt_q != FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign push_vld   = vld & rdy;
    // Popping only depends on occupancy, so a full FIFO still pops on a tick
    // while the same-cycle push is refused by rdy.
    assign pop_vld    = smpl_tick & ~fifo_empty;
    assign rd_dat     = fifo_mem[rd_ptr];
    assign fifo_cnt   = cnt_q;

    // Storage needs no reset: a slot is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_mem[wr_ptr] <= chnnl_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop_vld})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Duty registers hold the offset-binary form of the last popped sample.
    // Flipping the MSB maps signed -32768..32767 onto 0..65535 (for W=16),
    // so silence (0) becomes midscale and a 50% PDM density.
    // ------------------------------------------------------------------
    logic [NCH-1:0][W-1:0] duty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                duty_q[k] <= MID;
            end
        end else if (pop_vld) begin
            for (int k = 0; k < NCH; k++) begin
                duty_q[k] <= rd_dat[k*W +: W] ^ MID;
            end
        end
    end

    // Underrun: an empty-FIFO tick leaves the duty registers untouched (the
    // last sample is repeated) and raises a sticky flag. Clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (clr_err) begin
            underrun <= 1'b0;
        end else if (smpl_tick && fifo_empty) begin
            underrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Effective duty seen by the modulators, after muting.
    // ------------------------------------------------------------------
    logic [NCH-1:0][W-1:0] eff_duty;

`ifdef SPKR_SOFT_MUTE_EN
    // Attenuation step g per channel, 0 (full level) .. 32 (silence). It moves
    // one step per sample tick towards 32 while muted and towards 0 otherwise,
    // giving a click-free 32-sample fade in either direction.
    localparam logic [5:0] ATT_MAX = 6'd32;

    logic [NCH-1:0][5:0] att_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                att_q[k] <= 6'd0;
            end
        end else if (smpl_tick) begin
            for (int k = 0; k < NCH; k++) begin
                if (mute) begin
                    if (att_q[k] != ATT_MAX) begin
                        att_q[k] <= att_q[k] + 6'd1;
                    end
                end else if (att_q[k] != 6'd0) begin
                    att_q[k] <= att_q[k] - 6'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_soft_mute
        logic signed [W-1:0] smpl_s;
        logic signed [6:0]   gain_s;
        logic signed [W+6:0] prod_s;

        // Recover the signed sample, scale by (32-g)/32 and convert back.
        // |gain| <= 32, so the shifted product always fits back into W bits;
        // g = 32 yields exactly zero, i.e. exact midscale.
        assign smpl_s         = duty_q[k] ^ MID;
        assign gain_s         = {1'b0, ATT_MAX - att_q[k]};
        assign prod_s         = smpl_s * gain_s;
        assign eff_duty[k]    = W'(prod_s >>> 5) ^ MID;
    end
`else
    // Hard mute: registered so it lands on the same pipeline step as a new
    // duty value; FIFO pops carry on underneath and resume audibly on release.
    logic mute_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_q <= 1'b0;
        end else begin
            mute_q <= mute;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_hard_mute
        assign eff_duty[k] = mute_q ? MID : duty_q[k];
    end
`endif

    // ------------------------------------------------------------------
    // First-order PDM: accumulate the duty every clock; the carry out of the
    // W-bit accumulator is the output bit, so the density is duty / 2^W.
    // PDM and PDM_n come from separate flops on the same edge (no dead time).
    // ------------------------------------------------------------------
    logic [NCH-1:0][W-1:0] acc_q;
    logic [NCH-1:0][W:0]   acc_sum;

    for (genvar k = 0; k < NCH; k++) begin : g_pdm_sum
        assign acc_sum[k] = {1'b0, acc_q[k]} + {1'b0, eff_duty[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
            PDM   <= '0;
            PDM_n <= '1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_sum[k][W-1:0];
                PDM[k]   <= acc_sum[k][W];
                PDM_n[k] <= ~acc_sum[k][W];
            end
        end
    end

endmodule
